// File: rtl/regfile_access_ctrl.sv
// Operand-fetch front end for register_file: issues reads, queues writebacks, resolves RAW hazards.
// Define RAC_FWD_EN to forward queued writeback data instead of stalling on a hazard.
module regfile_access_ctrl #(
  parameter int WB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [4:0]  req_rd,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_val,
  output logic        op_valid,
  input  logic        op_ready,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [4:0]  op_rd,
  output logic [4:0]  rf_rs1,
  output logic [4:0]  rf_rs2,
  output logic        rf_read_en,
  input  logic [31:0] rf_r1,
  input  logic [31:0] rf_r2,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_dest_val,
  output logic        rf_write_en
);
  // state | meaning
  // IDLE  | waiting for a request; issue cycle drives rf read port
  // READ  | register_file data arrives; operands captured
  // HOLD  | operands presented until execute accepts
  localparam int PW = $clog2(WB_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, HOLD} state_t;
  state_t state, state_nx;

  logic [4:0]    fifo_rd  [WB_DEPTH];
  logic [31:0]   fifo_val [WB_DEPTH];
  logic [PW-1:0] head, tail, idx;
  logic [PW:0]   count;
  logic          full, empty, enq, issue, stall;
  logic          hit1, hit2;

  assign full     = (count == (PW+1)'(WB_DEPTH));
  assign empty    = (count == '0);
  assign wb_ready = ~full;
  // rd==0 writebacks are accepted but never stored, so x0 stays untouched
  assign enq      = wb_valid & ~full & (wb_rd != 5'd0);

`ifdef RAC_FWD_EN
  logic [31:0] fval1, fval2, fwd_val1, fwd_val2;
  logic        fwd_hit1, fwd_hit2;
`endif

  // Snapshot scan oldest to youngest so the last match wins; same-cycle wb is youngest.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    idx  = '0;
`ifdef RAC_FWD_EN
    fval1 = '0;
    fval2 = '0;
`endif
    for (int i = 0; i < WB_DEPTH; i++) begin
      idx = head + PW'(i);
      if ((PW+1)'(i) < count) begin
        if (req_rs1 != 5'd0 && fifo_rd[idx] == req_rs1) begin
          hit1 = 1'b1;
`ifdef RAC_FWD_EN
          fval1 = fifo_val[idx];
`endif
        end
        if (req_rs2 != 5'd0 && fifo_rd[idx] == req_rs2) begin
          hit2 = 1'b1;
`ifdef RAC_FWD_EN
          fval2 = fifo_val[idx];
`endif
        end
      end
    end
    if (enq && req_rs1 != 5'd0 && wb_rd == req_rs1) begin
      hit1 = 1'b1;
`ifdef RAC_FWD_EN
      fval1 = wb_val;
`endif
    end
    if (enq && req_rs2 != 5'd0 && wb_rd == req_rs2) begin
      hit2 = 1'b1;
`ifdef RAC_FWD_EN
      fval2 = wb_val;
`endif
    end
  end

`ifdef RAC_FWD_EN
  assign stall = 1'b0;
`else
  assign stall = hit1 | hit2;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    req_ready   = 1'b0;
    issue       = 1'b0;
    rf_read_en  = 1'b0;
    rf_rs1      = '0;
    rf_rs2      = '0;
    op_valid    = 1'b0;
    rf_write_en = 1'b0;
    rf_rd       = '0;
    rf_dest_val = '0;
    case (state)
      IDLE: begin
        req_ready = ~stall & ~rst;
        if (req_valid && req_ready) begin
          issue      = 1'b1;
          rf_read_en = 1'b1;
          rf_rs1     = req_rs1;
          rf_rs2     = req_rs2;
          state_nx   = READ;
        end
      end
      READ: state_nx = HOLD;
      HOLD: begin
        op_valid = ~rst;
        if (op_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    // the read port has priority; a drain never overlaps an issue
    if (!empty && !issue && !rst) begin
      rf_write_en = 1'b1;
      rf_rd       = fifo_rd[head];
      rf_dest_val = fifo_val[head];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      op_a  <= '0;
      op_b  <= '0;
      op_rd <= '0;
`ifdef RAC_FWD_EN
      fwd_hit1 <= 1'b0;
      fwd_hit2 <= 1'b0;
      fwd_val1 <= '0;
      fwd_val2 <= '0;
`endif
    end else begin
      if (enq)         tail <= tail + PW'(1);
      if (rf_write_en) head <= head + PW'(1);
      count <= count + (PW+1)'(enq) - (PW+1)'(rf_write_en);
      if (issue) begin
        op_rd <= req_rd;
`ifdef RAC_FWD_EN
        fwd_hit1 <= hit1;
        fwd_hit2 <= hit2;
        fwd_val1 <= fval1;
        fwd_val2 <= fval2;
`endif
      end
      if (state == READ) begin
`ifdef RAC_FWD_EN
        op_a <= fwd_hit1 ? fwd_val1 : rf_r1;
        op_b <= fwd_hit2 ? fwd_val2 : rf_r2;
`else
        op_a <= rf_r1;
        op_b <= rf_r2;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_rd[tail]  <= wb_rd;
      fifo_val[tail] <= wb_val;
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Bench for regfile_access_ctrl: register_file model, architectural-state scoreboard, directed + random stimulus.
module tb_regfile_access_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [4:0]  req_rs1, req_rs2, req_rd;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;
  logic        op_valid, op_ready;
  logic [31:0] op_a, op_b;
  logic [4:0]  op_rd;
  logic [4:0]  rf_rs1, rf_rs2, rf_rd;
  logic        rf_read_en, rf_write_en;
  logic [31:0] rf_r1, rf_r2, rf_dest_val;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.WB_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_val(wb_val),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b), .op_rd(op_rd),
    .rf_rs1(rf_rs1), .rf_rs2(rf_rs2), .rf_read_en(rf_read_en),
    .rf_r1(rf_r1), .rf_r2(rf_r2),
    .rf_rd(rf_rd), .rf_dest_val(rf_dest_val), .rf_write_en(rf_write_en)
  );

  // register_file: resets to xN=N, registered reads, 0 when not read
  logic [31:0] rf_mem [32];
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf_mem[i] <= 32'(i);
      rf_r1 <= '0;
      rf_r2 <= '0;
    end else begin
      rf_r1 <= rf_read_en ? rf_mem[rf_rs1] : 32'd0;
      rf_r2 <= rf_read_en ? rf_mem[rf_rs2] : 32'd0;
      if (rf_write_en && rf_rd != 5'd0) rf_mem[rf_rd] <= rf_dest_val;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb [$];
  exp_t        e_push, e_pop;
  logic [31:0] arch [32];
  int hs_cnt = 0, full_seen = 0, bad_x0 = 0, bad_both = 0, bad_rd = 0;

  // Architectural model: writebacks apply in acceptance order; a request sees every wb accepted up to its own cycle.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      for (int i = 0; i < 32; i++) arch[i] = 32'(i);
    end else begin
      if (rf_write_en && rf_rd == 5'd0) bad_x0++;
      if (rf_write_en && rf_read_en) bad_both++;
      if (rf_read_en != (req_valid && req_ready)) bad_rd++;
      if (wb_valid && !wb_ready) full_seen++;
      if (wb_valid && wb_ready && wb_rd != 5'd0) arch[wb_rd] = wb_val;
      if (req_valid && req_ready) begin
        e_push.a  = arch[req_rs1];
        e_push.b  = arch[req_rs2];
        e_push.rd = req_rd;
        sb.push_back(e_push);
      end
      if (op_valid && op_ready) begin
        hs_cnt++;
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e_pop = sb.pop_front();
          chk("op_a", op_a, e_pop.a);
          chk("op_b", op_b, e_pop.b);
          chk("op_rd", 32'(op_rd), 32'(e_pop.rd));
        end
      end
    end
  end

  // All stimulus tasks start and end just after a rising edge.
  task automatic wb_beat(input logic [4:0] rd, input logic [31:0] val);
    bit ok = 0;
    wb_valid = 1'b1; wb_rd = rd; wb_val = val;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (wb_ready) begin ok = 1; break; end
    end
    @(posedge clk); #1;
    wb_valid = 1'b0;
    if (!ok) chk("wb_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_req(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        output int waits);
    bit ok = 0;
    int lat;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    waits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (req_ready) begin ok = 1; break; end
      waits++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (!ok) begin
      chk("req_timeout", 32'd0, 32'd1);
      return;
    end
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (op_valid) break;
      lat++;
    end
    chk("latency", 32'(lat), 32'd2);
    if (op_ready) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, w2;
    rst = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0;
    wb_valid = 1'b0; wb_rd = '0; wb_val = '0; op_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_op_valid", 32'(op_valid), 32'd0);
    chk("rst_op_a", op_a, 32'd0);
    chk("rst_op_b", op_b, 32'd0);
    chk("rst_op_rd", 32'(op_rd), 32'd0);
    chk("rst_rf_read_en", 32'(rf_read_en), 32'd0);
    chk("rst_rf_write_en", 32'(rf_write_en), 32'd0);
    chk("rst_wb_ready", 32'(wb_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // plain read of reset values
    do_req(5'd5, 5'd7, 5'd3, w);
    chk("t1_wait", 32'(w), 32'd0);

    // RAW against a just-accepted writeback
    wb_beat(5'd5, 32'hDEADBEEF);
    do_req(5'd5, 5'd1, 5'd2, w);
`ifdef RAC_FWD_EN
    chk("t2_wait", 32'(w), 32'd0);
`else
    chk("t2_wait", 32'(w), 32'd1);
`endif

    // youngest of two writes to the same register wins
    wb_beat(5'd9, 32'h11);
    wb_beat(5'd9, 32'h22);
    do_req(5'd9, 5'd9, 5'd1, w);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_x9", rf_mem[9], 32'h22);
    do_req(5'd9, 5'd0, 5'd6, w);

    // x0 writeback is dropped, never stalls
    wb_beat(5'd0, 32'h55);
    do_req(5'd0, 5'd0, 5'd7, w);
    chk("t4_wait", 32'(w), 32'd0);

    // backpressure in HOLD
    op_ready = 1'b0;
    do_req(5'd11, 5'd12, 5'd4, w);
    for (int k = 0; k < 4; k++) begin
      chk("t5_op_valid", 32'(op_valid), 32'd1);
      chk("t5_op_a", op_a, 32'd11);
      chk("t5_op_b", op_b, 32'd12);
      chk("t5_op_rd", 32'(op_rd), 32'd4);
      chk("t5_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    op_ready = 1'b1;
    @(negedge clk);
    chk("t5_hs", 32'(op_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_idle_op_valid", 32'(op_valid), 32'd0);
    chk("t5_idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;

    // reset during READ with two queued writes
    wb_valid = 1'b1; wb_rd = 5'd5; wb_val = 32'hAAAA;
    @(posedge clk); #1;
    wb_rd = 5'd6; wb_val = 32'hBBBB;
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2; req_rd = 5'd9;
    @(negedge clk);
    chk("t6_req_acc", 32'(req_ready), 32'd1);
    chk("t6_wb_acc", 32'(wb_ready), 32'd1);
    @(posedge clk); #1;
    wb_valid = 1'b0; req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_write_en", 32'(rf_write_en), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t6_op_valid", 32'(op_valid), 32'd0);
    chk("t6_write_en", 32'(rf_write_en), 32'd0);
    chk("t6_wb_ready", 32'(wb_ready), 32'd1);
    @(posedge clk); #1;
    do_req(5'd5, 5'd6, 5'd8, w);

    // continuous writebacks against back-to-back requests fill the queue
    fork
      begin
        for (int i = 0; i < 20; i++) wb_beat(5'(16 + (i % 16)), 32'h1000 + 32'(i));
      end
      begin
        for (int j = 0; j < 8; j++) do_req(5'd1, 5'd2, 5'(j), w2);
      end
    join
    chk("full_seen", 32'(full_seen > 0), 32'd1);
    do_req(5'd31, 5'd16, 5'd10, w);
    do_req(5'd17, 5'd20, 5'd11, w);

    // random mix
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(1) == 1) wb_beat(5'($urandom_range(7)), $urandom);
      do_req(5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom_range(31)), w);
    end

    repeat (10) @(posedge clk);
    #1;
    chk("no_x0_write", 32'(bad_x0), 32'd0);
    chk("no_rw_overlap", 32'(bad_both), 32'd0);
    chk("read_only_on_issue", 32'(bad_rd), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("hs_seen", 32'(hs_cnt > 40), 32'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
